// File: rtl/seven_seg_scanner_if.sv
// Request-side bundle for seven_seg_scanner: value/load handshake, busy status and decimal-point mask.
interface seven_seg_scanner_if #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned BIN_W  = 27
);
    logic [BIN_W-1:0]  value;
    logic              load;
    logic [DIGITS-1:0] dp_mask;
    logic              busy;

    modport master (output value, output load, output dp_mask, input busy);
    modport slave  (input value, input load, input dp_mask, output busy);
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment driver with a sequential double-dabble converter.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scanner #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned BIN_W       = 27,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clock,
    input  logic              reset,
    seven_seg_scanner_if.slave bus,
    output logic [6:0]        cathode,
    output logic              dp,
    output logic [DIGITS-1:0] anode
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned MAX_DEC = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t            state;
    logic [BIN_W-1:0]  bin_sr;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  iter;
    logic              ovf_cap;
    logic              ovf;
    logic              busy_q;
    logic [BCD_W-1:0]  disp;

    logic [PRE_W-1:0]  presc;
    logic [IDX_W-1:0]  idx;
    logic              tick_c;
    logic [3:0]        nib_sel;
    logic [DIGITS-1:0] blank;

    // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bin_sr  <= '0;
            bcd     <= '0;
            iter    <= '0;
            ovf_cap <= 1'b0;
            ovf     <= 1'b0;
            busy_q  <= 1'b0;
            disp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin_sr  <= bus.value;
                        bcd     <= '0;
                        iter    <= CNT_W'(BIN_W);
                        ovf_cap <= (64'(bus.value) > MAX_DEC);
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Bits pushed beyond the top nibble fall off; overflow is flagged separately.
                    bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= bin_sr << 1;
                    iter   <= iter - CNT_W'(1);
                    if (iter == CNT_W'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp   <= bcd;
                    ovf    <= ovf_cap;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;

`ifdef SEVEN_SEG_LZB_EN
    logic lzb_seen;

    // Blank digits above the most significant nonzero one; digit 0 always shows.
    always_comb begin
        blank    = '0;
        lzb_seen = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (disp[4*i +: 4] != 4'd0) lzb_seen = 1'b1;
            blank[i] = !lzb_seen && !ovf;
        end
    end
`else
    assign blank = '0;
`endif

    assign tick_c  = (presc == PRE_W'(REFRESH_DIV - 1));
    assign nib_sel = disp[{idx, 2'b00} +: 4];

    // Digit scan: outputs only move on refresh ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc   <= '0;
            idx     <= '0;
            anode   <= '1;
            cathode <= 7'b1111111;
            dp      <= 1'b1;
        end else if (tick_c) begin
            presc   <= '0;
            anode   <= ~(DIGITS'(1) << idx);
            dp      <= ~bus.dp_mask[idx];
            if (ovf)             cathode <= 7'b0111111;
            else if (blank[idx]) cathode <= 7'b1111111;
            else                 cathode <= seg_decode(nib_sel);
            idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: stimulus queues expected per-slot outputs, a monitor checks each tick.
module tb_seven_seg_scanner;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BIN_W  = 27;
    localparam int unsigned RD     = 4;

    typedef struct {
        int         slot;
        logic [7:0] anode;
        logic [6:0] cathode;
        logic       dp;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic [6:0] cathode;
    logic dp;
    logic [7:0] anode;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];
    exp_t mon_e;

    int   m_presc;
    int   slot_no;
    logic tick_seen;

    seven_seg_scanner_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    seven_seg_scanner #(.DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_DIV(RD)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .cathode(cathode),
        .dp     (dp),
        .anode  (anode)
    );

    always #5 clock = ~clock;

    // Reference refresh timing: tick every RD cycles, slot k drives digit (k-1) mod DIGITS.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_presc   <= 0;
            slot_no   <= 0;
            tick_seen <= 1'b0;
        end else if (m_presc == RD - 1) begin
            m_presc   <= 0;
            slot_no   <= slot_no + 1;
            tick_seen <= 1'b1;
        end else begin
            m_presc   <= m_presc + 1;
            tick_seen <= 1'b0;
        end
    end

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int dec_digit(input longint v, input int d);
        longint p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return int'((v / p) % 10);
    endfunction

    function automatic exp_t make_exp(input int slot, input longint v, input logic [7:0] mask);
        exp_t e;
        logic [7:0] one = 8'd1;
        int d = (slot - 1) % DIGITS;
        int msd = 0;
        bit ovf = (v > 64'd99999999);
        for (int k = 0; k < DIGITS; k++) if (dec_digit(v, k) != 0) msd = k;
        e.slot  = slot;
        e.anode = ~(one << d);
        e.dp    = ~mask[d];
        if (ovf) e.cathode = 7'b0111111;
        else     e.cathode = ref_seg(dec_digit(v, d));
`ifdef SEVEN_SEG_LZB_EN
        if (!ovf && d > 0 && d > msd) e.cathode = 7'b1111111;
`endif
        return e;
    endfunction

    task automatic push_frame(input longint v);
        int cur = slot_no;
        for (int k = 1; k <= DIGITS; k++) sb.push_back(make_exp(cur + k, v, bus.dp_mask));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected slots never shown (need 0)", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still high after %0d cycles (need low)", n);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, req);
        end
    endtask

    task automatic do_load(input longint v);
        @(negedge clock);
        bus.value = BIN_W'(v);
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
    endtask

    task automatic convert_and_check(input longint v, input string name);
        int n;
        do_load(v);
        wait_idle(n);
        check({name, "_busy_cycles"}, 32'(n), 32'(BIN_W + 1));
        push_frame(v);
        wait_drain();
    endtask

    // Monitor: compare each refresh slot against the queued expectation.
    always @(negedge clock) begin
        if (!reset && tick_seen) begin
            while (sb.size() > 0 && sb[0].slot < slot_no) begin
                checks++;
                errors++;
                $display("FAIL missed_slot: slot %0d passed unchecked at slot %0d", sb[0].slot, slot_no);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].slot == slot_no) begin
                mon_e = sb.pop_front();
                checks++;
                if (anode !== mon_e.anode || cathode !== mon_e.cathode || dp !== mon_e.dp) begin
                    errors++;
                    $display("FAIL slot%0d: anode=%b cathode=%b dp=%b, need anode=%b cathode=%b dp=%b",
                             slot_no, anode, cathode, dp, mon_e.anode, mon_e.cathode, mon_e.dp);
                end
            end
        end
    end

    initial begin
        int n;
        reset        = 1'b1;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.dp_mask  = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_anode", 32'(anode), 32'hff);
        check("rst_cathode", 32'(cathode), 32'h7f);
        check("rst_dp", 32'(dp), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        push_frame(0);
        wait_drain();

        convert_and_check(12345678, "v12345678");
        convert_and_check(100000000, "ovf");
        convert_and_check(99999999, "v99999999");
        convert_and_check(42, "v42");
        convert_and_check(0, "v0");

        // Second load five cycles into a conversion must be dropped.
        do_load(11111111);
        repeat (4) @(negedge clock);
        bus.value = BIN_W'(22222222);
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        wait_idle(n);
        push_frame(11111111);
        wait_drain();

        // Earliest re-accept at E+BIN_W+2, with a decimal point on digit 2.
        bus.dp_mask = 8'b00000100;
        do_load(55555555);
        repeat (BIN_W + 1) @(negedge clock);
        check("busy_low_after_commit", 32'(bus.busy), 32'd0);
        bus.value = BIN_W'(87654321);
        bus.load  = 1'b1;
        @(negedge clock);
        bus.load  = 1'b0;
        check("reaccept_busy", 32'(bus.busy), 32'd1);
        wait_idle(n);
        push_frame(87654321);
        wait_drain();
        bus.dp_mask = '0;

        // Asynchronous reset in the middle of a conversion.
        do_load(12345678);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_anode", 32'(anode), 32'hff);
        check("midrst_cathode", 32'(cathode), 32'h7f);
        check("midrst_dp", 32'(dp), 32'd1);
        @(negedge clock);
        reset = 1'b0;
        push_frame(0);
        wait_drain();
        wait_idle(n);
        check("midrst_busy_after", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised multiplexed seven-segment driver. It accepts an unsigned binary value on a load strobe and converts it to BCD with a multi-cycle sequential double-dabble engine. It scans `DIGITS` common-anode displays at a programmable refresh rate, with per-digit decimal points, overflow indication and optional leading-zero blanking. It sits between the application datapath and the board's anode/cathode pins.

## Interface
- `DIGITS`, 8: number of display digits (1..8).
- `BIN_W`, 27: width of the binary input value.
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥2.
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `value` in `BIN_W`: unsigned binary value, sampled on accepted `load`.
- `load` in 1: request conversion of `value`.
- `dp_mask` in `DIGITS`: bit i=1 lights the decimal point of digit i; sampled live at each refresh tick.
- `busy` out 1: conversion in progress; `load` ignored while high.
- `cathode` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `anode` out `DIGITS`: digit enables, active-low one-hot; digit 0 is the least significant digit.

## Operation
- **Converter FSM states:**
  - IDLE: `load`=1 captures `value` into the shift register, clears the BCD accumulator (4·`DIGITS` bits), loads an iteration counter with `BIN_W`, and moves to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1 and decrement the counter. After the `BIN_W`-th shift, move to COMMIT.
  - COMMIT: write the accumulator to the display register, write the overflow flag, return to IDLE.
- **Overflow:** set when the captured `value` > 10^`DIGITS`−1, compared at capture. While set, every digit shows a dash (7'b0111111). BCD bits shifted past the top nibble are discarded.
- **Scan:**
  - A prescaler counts 0..`REFRESH_DIV`−1 and produces a one-cycle tick at terminal count.
  - On a tick, outputs are driven for digit `idx`, then `idx` increments, wrapping from `DIGITS`−1 to 0.
  - Output values on a tick: `anode` = all ones except bit `idx`; `cathode` = decoded nibble `idx` of the display register; `dp` = ~`dp_mask[idx]`.
- **Decode:** 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Non-BCD nibbles → blank (1111111).
- **Boundary conditions:**
  - `load` while `busy` is dropped and not queued.
  - A commit mid-slot does not alter the current outputs; new data appears from the next tick.
  - `reset` mid-conversion aborts to IDLE and clears the display register.

## Timing
- **Reset values:** `anode`=all ones, `cathode`=7'b1111111, `dp`=1, `busy`=0, `idx`=0, prescaler=0, display register=0, overflow=0, FSM=IDLE.
- **Conversion timing:**
  - `load` accepted at edge E.
  - `busy`=1 after E; shifts occur on E+1..E+`BIN_W`.
  - Commit occurs at E+`BIN_W`+1, where `busy` falls.
  - `busy` is high for exactly `BIN_W`+1 cycles.
  - A new `load` is accepted at the commit edge only if `busy` was 0 when sampled, so the earliest re-accept is E+`BIN_W`+2.
- **Scan timing:**
  - The first tick occurs `REFRESH_DIV` cycles after reset release, driving digit 0.
  - Each digit is held for `REFRESH_DIV` cycles; a full frame lasts `DIGITS`·`REFRESH_DIV` cycles.
  - All outputs are registered and change only on tick edges.

## Configuration
- **With `SEVEN_SEG_LZB_EN` defined:** leading-zero blanking. Every digit above the most significant nonzero nibble drives `cathode`=1111111; its anode is still strobed and `dp` still follows `dp_mask`. Digit 0 is never blanked, so value 0 shows "0". Blanking is disabled while overflow is set.
- **Without `SEVEN_SEG_LZB_EN`:** all `DIGITS` nibbles are displayed, including leading zeros.

## Test plan
- Reset, then `REFRESH_DIV`=4, `DIGITS`=8. `load` of 27'd12345678 → `busy` high for 28 cycles. Over the next frame, digits 0..7 show 8,7,6,5,4,3,2,1, with `anode` 11111110 → 01111111 in order, each held 4 cycles.
- `DIGITS`=4, `load` of 10000 → all four digits show 0111111 (dash). A following `load` of 9999 → all digits show 0010000.
- With `SEVEN_SEG_LZB_EN`, `load` of 42 → digits 0,1 show 0010101-free decode of 2 (0100100) and 4 (0011001); digits 2..7 show 1111111. `load` of 0 → digit 0 shows 1000000.
- `load` pulses at E and E+5 → only the first value is displayed. `load` at E+29 (`BIN_W`=27) is accepted.
- Assert `reset` at E+10 of a conversion → `busy`=0, FSM is IDLE, and all outputs are at their reset values immediately, with no clock edge required. After release, digits show 0.
- `dp_mask`=8'b00000100 → `dp`=0 only while `anode`=11111011.
